// File: rtl/rbm_dma_scheduler_pkg.sv
// rbm_pkg: shared FSM state type and datapath widths for the RBM DMA scheduler
package rbm_pkg;
  localparam int ADDR_W = 32;
  localparam int CNT_W = 16;
  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_XFER, COMPUTE, WR_REQ, WR_XFER, NEXT, FINISH
  } rbm_dma_state_e;
endpackage

// File: rtl/rbm_dma_scheduler_if.sv
// rbm_dma_scheduler_if: read/write DMA handshake and datapath launch signals
interface rbm_dma_scheduler_if;
  logic rd_request;
  logic [rbm_pkg::ADDR_W-1:0] rd_index;
  logic [rbm_pkg::ADDR_W-1:0] rd_length;
  logic rd_grant;
  logic rd_beat;
  logic rd_complete;
  logic comp_start;
  logic comp_done;
  logic wr_request;
  logic [rbm_pkg::ADDR_W-1:0] wr_index;
  logic [rbm_pkg::ADDR_W-1:0] wr_length;
  logic wr_grant;
  logic wr_beat;
  logic wr_complete;
  modport master (
    output rd_request, rd_index, rd_length, rd_complete, comp_start,
    output wr_request, wr_index, wr_length, wr_complete,
    input rd_grant, rd_beat, comp_done, wr_grant, wr_beat
  );
  modport slave (
    input rd_request, rd_index, rd_length, rd_complete, comp_start,
    input wr_request, wr_index, wr_length, wr_complete,
    output rd_grant, rd_beat, comp_done, wr_grant, wr_beat
  );
endinterface

// File: rtl/rbm_dma_scheduler_xfer_counter.sv
// rbm_xfer_counter: beat counter flagging the final beat and an already-met limit
module rbm_xfer_counter import rbm_pkg::*; (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  input  logic [CNT_W-1:0] limit,
  output logic term,
  output logic last
);
  logic [CNT_W-1:0] cnt;
  assign term = cnt == limit;
  assign last = inc && !term && (cnt + CNT_W'(1) == limit);
  // count accepted beats, saturating at the limit so extra beats are dropped
  always_ff @(posedge clk)
    cnt <= (rst || clr) ? '0 : (inc && !term) ? cnt + CNT_W'(1) : cnt;
endmodule

// File: rtl/rbm_dma_scheduler.sv
// rbm_dma_scheduler: per-user read/compute/write sequencing over all RBM training loops
module rbm_dma_scheduler import rbm_pkg::*; #(
  parameter logic [ADDR_W-1:0] RD_BASE = 32'h0000_0000,
  parameter logic [ADDR_W-1:0] WR_BASE = 32'h0010_0000
) (
  input  logic clk,
  input  logic rst,
  input  logic init_done,
  input  logic [CNT_W-1:0] num_users,
  input  logic [CNT_W-1:0] num_loops,
  input  logic [CNT_W-1:0] num_movies,
  rbm_dma_scheduler_if.master bus,
  output logic [CNT_W-1:0] cur_user,
  output logic [CNT_W-1:0] cur_loop,
  output logic done
);
  rbm_dma_state_e state, state_n;
  logic [ADDR_W-1:0] offset, offset_n, movies_w, rd_index, wr_index, rd_length, wr_length;
  logic rd_term, rd_last, wr_term, wr_last, last_user, last_loop, start, comp_start;
  assign movies_w = {{(ADDR_W-CNT_W){1'b0}}, num_movies};
  assign last_user = cur_user == num_users - CNT_W'(1);
  assign last_loop = cur_loop == num_loops - CNT_W'(1);
  assign start = state == IDLE && init_done && !done;
  assign offset_n = last_user ? '0 : offset + movies_w;
  rbm_xfer_counter u_rd_cnt (
    .clk(clk), .rst(rst), .clr(state == RD_REQ && bus.rd_grant),
    .inc(state == RD_XFER && bus.rd_beat), .limit(num_movies),
    .term(rd_term), .last(rd_last)
  );
  rbm_xfer_counter u_wr_cnt (
    .clk(clk), .rst(rst), .clr(state == WR_REQ && bus.wr_grant),
    .inc(state == WR_XFER && bus.wr_beat), .limit(num_movies),
    .term(wr_term), .last(wr_last)
  );
  // state register
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;
  // next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = (num_users == '0 || num_loops == '0) ? FINISH : RD_REQ;
      RD_REQ:  if (bus.rd_grant) state_n = RD_XFER;
      RD_XFER: if (rd_term || rd_last) state_n = COMPUTE;
      COMPUTE: if (bus.comp_done) state_n = WR_REQ;
      WR_REQ:  if (bus.wr_grant) state_n = WR_XFER;
      WR_XFER: if (wr_term || wr_last) state_n = NEXT;
      NEXT:    state_n = (last_user && last_loop) ? FINISH : RD_REQ;
      default: state_n = FINISH;
    endcase
  end
  // user/loop position, addresses and sticky completion
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_user <= '0;
      cur_loop <= '0;
      offset <= '0;
      rd_index <= '0;
      wr_index <= '0;
      rd_length <= '0;
      wr_length <= '0;
      comp_start <= 1'b0;
      done <= 1'b0;
    end else begin
      comp_start <= state != COMPUTE && state_n == COMPUTE;
      done <= done || state_n == FINISH;
      if (start) begin
        cur_user <= '0;
        cur_loop <= '0;
        offset <= '0;
        rd_index <= RD_BASE;
        wr_index <= WR_BASE;
        rd_length <= movies_w;
        wr_length <= movies_w;
      end else if (state == NEXT) begin
        cur_user <= last_user ? '0 : cur_user + CNT_W'(1);
        cur_loop <= last_user ? cur_loop + CNT_W'(1) : cur_loop;
        offset <= offset_n;
        rd_index <= RD_BASE + offset_n;
        wr_index <= WR_BASE + offset_n;
      end
    end
  end
  // bus outputs decoded from state
  always_comb begin
    bus.rd_request = state == RD_REQ;
    bus.wr_request = state == WR_REQ;
    bus.rd_complete = state == RD_XFER && rd_last;
    bus.wr_complete = state == WR_XFER && wr_last;
    bus.comp_start = comp_start;
    bus.rd_index = rd_index;
    bus.wr_index = wr_index;
    bus.rd_length = rd_length;
    bus.wr_length = wr_length;
  end
endmodule

// File: tb/tb_rbm_dma_scheduler.sv
// tb_rbm_dma_scheduler: scoreboard bench driving grants/beats and checking addresses and pulses
module tb_rbm_dma_scheduler;
  import rbm_pkg::*;
  typedef struct {
    logic [31:0] rd;
    logic [31:0] wr;
    logic [15:0] user;
    logic [15:0] loop;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic init_done = 1'b0;
  logic [15:0] num_users = '0, num_loops = '0, num_movies = '0;
  logic [15:0] cur_user, cur_loop;
  logic done;
  exp_t sb[$];
  int n_tests = 0, n_fail = 0;
  int n_rdc = 0, n_wrc = 0, n_cs = 0, n_req = 0, n_both = 0;
  rbm_dma_scheduler_if bus();
  rbm_dma_scheduler dut (
    .clk(clk), .rst(rst), .init_done(init_done),
    .num_users(num_users), .num_loops(num_loops), .num_movies(num_movies),
    .bus(bus), .cur_user(cur_user), .cur_loop(cur_loop), .done(done)
  );
  always #5 clk = ~clk;
  // pulse and request accounting, sampled mid-cycle
  always @(negedge clk) begin
    if (rst) begin
      n_rdc <= 0;
      n_wrc <= 0;
      n_cs <= 0;
      n_req <= 0;
      n_both <= 0;
    end else begin
      n_rdc <= n_rdc + int'(bus.rd_complete);
      n_wrc <= n_wrc + int'(bus.wr_complete);
      n_cs <= n_cs + int'(bus.comp_start);
      n_req <= n_req + int'(bus.rd_request | bus.wr_request);
      n_both <= n_both + int'(bus.rd_request & bus.wr_request);
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic sig(input int sel);
    return sel == 0 ? bus.rd_request : sel == 1 ? bus.wr_request : done;
  endfunction
  task automatic wait_sig(input int sel, input string tag);
    int t = 0;
    while (!sig(sel) && t < 100) begin
      tick();
      t++;
    end
    chk(tag, sig(sel), 1);
  endtask
  task automatic apply_reset();
    rst = 1'b1;
    init_done = 1'b0;
    bus.rd_grant = 1'b0;
    bus.rd_beat = 1'b0;
    bus.wr_grant = 1'b0;
    bus.wr_beat = 1'b0;
    bus.comp_done = 1'b0;
    sb.delete();
    tick();
    tick();
    rst = 1'b0;
  endtask
  task automatic check_zero(input string tag);
    chk({tag, "_rd_request"}, bus.rd_request, 0);
    chk({tag, "_wr_request"}, bus.wr_request, 0);
    chk({tag, "_rd_index"}, bus.rd_index, 0);
    chk({tag, "_wr_index"}, bus.wr_index, 0);
    chk({tag, "_rd_length"}, bus.rd_length, 0);
    chk({tag, "_wr_length"}, bus.wr_length, 0);
    chk({tag, "_comp_start"}, bus.comp_start, 0);
    chk({tag, "_cur_user"}, cur_user, 0);
    chk({tag, "_cur_loop"}, cur_loop, 0);
    chk({tag, "_done"}, done, 0);
  endtask
  task automatic push_exp(input logic [15:0] u, input logic [15:0] l, input logic [15:0] m);
    for (int lp = 0; lp < int'(l); lp++)
      for (int us = 0; us < int'(u); us++)
        sb.push_back('{rd: 32'(us) * 32'(m), wr: 32'h0010_0000 + 32'(us) * 32'(m),
                       user: 16'(us), loop: 16'(lp)});
  endtask
  task automatic do_read(input logic [15:0] m, input int gdelay, input int extra, output exp_t e);
    e = '{rd: '0, wr: '0, user: '0, loop: '0};
    wait_sig(0, "rd_request_seen");
    chk("sb_nonempty", sb.size() > 0, 1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk("rd_index", bus.rd_index, e.rd);
    chk("rd_length", bus.rd_length, {16'd0, m});
    chk("cur_user", cur_user, e.user);
    chk("cur_loop", cur_loop, e.loop);
    for (int i = 0; i < gdelay; i++) begin
      bus.rd_beat = 1'b1;
      tick();
      bus.rd_beat = 1'b0;
      chk("rd_hold_request", bus.rd_request, 1);
      chk("rd_hold_index", bus.rd_index, e.rd);
    end
    bus.rd_grant = 1'b1;
    tick();
    bus.rd_grant = 1'b0;
    chk("rd_request_drop", bus.rd_request, 0);
    for (int i = 0; i < int'(m) + extra; i++) begin
      bus.rd_beat = 1'b1;
      #1;
      chk("rd_complete", bus.rd_complete, 32'(i == int'(m) - 1));
      tick();
      bus.rd_beat = 1'b0;
    end
    if (extra == 0) chk("comp_start", bus.comp_start, 1);
  endtask
  task automatic do_compute();
    bus.comp_done = 1'b1;
    tick();
    bus.comp_done = 1'b0;
  endtask
  task automatic do_write(input logic [15:0] m, input exp_t e);
    wait_sig(1, "wr_request_seen");
    chk("wr_index", bus.wr_index, e.wr);
    chk("wr_length", bus.wr_length, {16'd0, m});
    bus.wr_grant = 1'b1;
    tick();
    bus.wr_grant = 1'b0;
    chk("wr_request_drop", bus.wr_request, 0);
    for (int i = 0; i < int'(m); i++) begin
      bus.wr_beat = 1'b1;
      #1;
      chk("wr_complete", bus.wr_complete, 32'(i == int'(m) - 1));
      tick();
      bus.wr_beat = 1'b0;
    end
  endtask
  task automatic run_case(input logic [15:0] u, input logic [15:0] l, input logic [15:0] m,
                          input int gdelay, input int extra);
    exp_t e;
    int n;
    apply_reset();
    num_users = u;
    num_loops = l;
    num_movies = m;
    push_exp(u, l, m);
    init_done = 1'b1;
    n = int'(u) * int'(l);
    for (int k = 0; k < n; k++) begin
      do_read(m, gdelay, extra, e);
      do_compute();
      do_write(m, e);
    end
    wait_sig(2, "done_seen");
    tick();
    chk("rd_complete_count", n_rdc, n);
    chk("comp_start_count", n_cs, n);
    chk("wr_complete_count", n_wrc, n);
    chk("req_overlap", n_both, 0);
    chk("sb_drained", sb.size(), 0);
  endtask
  initial begin
    exp_t e;
    apply_reset();
    check_zero("reset");
    run_case(16'd2, 16'd1, 16'd4, 0, 0);
    run_case(16'd1, 16'd1, 16'd3, 10, 0);
    run_case(16'd3, 16'd2, 16'd5, 0, 0);
    run_case(16'd1, 16'd1, 16'd4, 0, 2);
    apply_reset();
    num_users = 16'd0;
    num_loops = 16'd1;
    num_movies = 16'd4;
    init_done = 1'b1;
    tick();
    tick();
    chk("done_zero_users", done, 1);
    repeat (5) tick();
    chk("done_sticky", done, 1);
    chk("zero_users_requests", n_req, 0);
    apply_reset();
    num_users = 16'd2;
    num_loops = 16'd1;
    num_movies = 16'd4;
    push_exp(16'd2, 16'd1, 16'd4);
    init_done = 1'b1;
    do_read(16'd4, 0, 0, e);
    do_compute();
    wait_sig(1, "wr_request_seen");
    bus.wr_grant = 1'b1;
    tick();
    bus.wr_grant = 1'b0;
    bus.wr_beat = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    tick();
    bus.wr_beat = 1'b0;
    check_zero("rst_mid");
    chk("rst_mid_wr_complete", bus.wr_complete, 0);
    rst = 1'b0;
    sb.delete();
    push_exp(16'd2, 16'd1, 16'd4);
    do_read(16'd4, 0, 0, e);
    do_compute();
    do_write(16'd4, e);
    do_read(16'd4, 0, 0, e);
    chk("restart_user1", cur_user, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
